// File: rtl/m_weight_scheduler_pkg.sv
// Shared parameters and FSM state encoding for the M-weight scheduler.
package m_weight_scheduler_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int ROW_LEN_DEF  = 8;
    localparam int NUM_ROWS_DEF = 64;
    localparam int ADDR_W_DEF   = 9;
    localparam int PEND_MAX_DEF = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_BURST = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/m_weight_scheduler_credit.sv
// Saturating up/down counter of queued burst requests; flags a request lost at the limit.
module request_credit_counter #(
    parameter int MAX = 15,
    parameter int W   = 4
) (
    input  logic         clock,
    input  logic         clear_n,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_count,
    output logic         o_overflow
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] r_count;

    // A simultaneous increment and decrement cancel, so only a lone increment can overflow.
    assign o_overflow = i_inc && !i_dec && (r_count == MAX_V);
    assign o_count    = r_count;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_count <= '0;
        end else if (i_inc && !i_dec && (r_count != MAX_V)) begin
            r_count <= r_count + W'(1);
        end else if (i_dec && !i_inc && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

endmodule

// File: rtl/m_weight_scheduler.sv
// Streams ROW_LEN-weight bursts from the weight RAM on request and lets the host preload the RAM when idle.
module m_weight_scheduler
    import m_weight_scheduler_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ROW_LEN  = ROW_LEN_DEF,
    parameter int NUM_ROWS = NUM_ROWS_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int PEND_MAX = PEND_MAX_DEF
) (
    input  logic              clock,
    input  logic              clear_n,
    input  logic              start,
    input  logic              m_element_requested,
    output logic [DATA_W-1:0] m_element,
    output logic              m_element_ready,
    output logic              last_m_element,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_enable,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              host_write,
    input  logic [ADDR_W-1:0] host_address,
    input  logic [DATA_W-1:0] host_data,
    output logic              busy,
    output logic              finished,
    output logic              error
);

    localparam int ROW_W   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int ELEM_W  = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
    localparam int PEND_W  = $clog2(PEND_MAX + 1);
    localparam int QUEUE_W = $clog2(NUM_ROWS + 1);

    localparam logic [ROW_W-1:0]   LAST_ROW  = ROW_W'(NUM_ROWS - 1);
    localparam logic [ELEM_W-1:0]  LAST_ELEM = ELEM_W'(ROW_LEN - 1);
    localparam logic [QUEUE_W-1:0] ALL_ROWS  = QUEUE_W'(NUM_ROWS);
    localparam logic [ADDR_W-1:0]  ROW_LEN_A = ADDR_W'(ROW_LEN);

    generate
        if (ROW_LEN * NUM_ROWS > 2 ** ADDR_W) begin : g_addrCheck
            $error("weight RAM address too narrow for ROW_LEN*NUM_ROWS");
        end
    endgenerate

    sched_state_t        r_state, w_nextState;
    logic [ROW_W-1:0]    r_row;
    logic [ELEM_W-1:0]   r_elem;
    logic [QUEUE_W-1:0]  r_queued;
    logic                r_valid, r_last, r_error;
    logic [PEND_W-1:0]   w_pendCount;
    logic                w_overflow, w_running, w_idleLike, w_lastIssue, w_lastRow;
    logic                w_reqAccept, w_reqStored, w_burstEnter, w_startRun, w_errEvent;

    assign w_running   = (r_state == ST_ARMED) || (r_state == ST_BURST);
    assign w_idleLike  = !w_running;
    assign w_lastIssue = (r_state == ST_BURST) && (r_elem == LAST_ELEM);
    assign w_lastRow   = (r_row == LAST_ROW);
    assign w_startRun  = start && w_idleLike;
    assign w_reqAccept = m_element_requested && w_running && (r_queued != ALL_ROWS);
    assign w_reqStored = w_reqAccept && !w_overflow;
    // A request arriving in the deciding cycle counts as pending so back-to-back bursts have no gap.
    assign w_burstEnter = ((r_state == ST_ARMED) || (w_lastIssue && !w_lastRow))
                          && ((w_pendCount != '0) || w_reqAccept);
    assign w_errEvent  = (m_element_requested && !w_reqAccept) || w_overflow
                         || (host_write && w_running);

    request_credit_counter #(
        .MAX (PEND_MAX),
        .W   (PEND_W)
    ) u_credit (
        .clock      (clock),
        .clear_n    (clear_n),
        .i_inc      (w_reqAccept),
        .i_dec      (w_burstEnter),
        .o_count    (w_pendCount),
        .o_overflow (w_overflow)
    );

    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            ST_IDLE:  if (start) w_nextState = ST_ARMED;
            ST_ARMED: if (w_burstEnter) w_nextState = ST_BURST;
            ST_BURST: begin
                if (w_lastIssue) begin
                    if (w_lastRow)         w_nextState = ST_DONE;
                    else if (w_burstEnter) w_nextState = ST_BURST;
                    else                   w_nextState = ST_ARMED;
                end
            end
            ST_DONE:  if (start) w_nextState = ST_ARMED;
            default:  w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_state  <= ST_IDLE;
            r_row    <= '0;
            r_elem   <= '0;
            r_queued <= '0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_valid <= (r_state == ST_BURST);
            r_last  <= w_lastIssue;
            r_error <= r_error | w_errEvent;
            if (w_startRun) begin
                r_row    <= '0;
                r_elem   <= '0;
                r_queued <= '0;
            end else begin
                if (r_state == ST_BURST) begin
                    if (w_lastIssue) begin
                        r_elem <= '0;
                        if (!w_lastRow) r_row <= r_row + ROW_W'(1);
                    end else begin
                        r_elem <= r_elem + ELEM_W'(1);
                    end
                end
                if (w_reqStored) r_queued <= r_queued + QUEUE_W'(1);
            end
        end
    end

    // The RAM port belongs to the burst reader while running and to the host otherwise.
    always_comb begin
        ram_enable  = 1'b0;
        ram_write   = 1'b0;
        ram_address = '0;
        ram_wdata   = '0;
        if (r_state == ST_BURST) begin
            ram_enable  = 1'b1;
            ram_address = ADDR_W'(r_row) * ROW_LEN_A + ADDR_W'(r_elem);
        end else if (w_idleLike && host_write) begin
            ram_enable  = 1'b1;
            ram_write   = 1'b1;
            ram_address = host_address;
            ram_wdata   = host_data;
        end
    end

    assign m_element       = r_valid ? ram_rdata : '0;
    assign m_element_ready = r_valid;
    assign last_m_element  = r_last;
    assign busy            = w_running;
    assign finished        = (r_state == ST_DONE);
    assign error           = r_error;

endmodule
